friscv_sensor_copo: RTL and testbench

Parametrised cup-presence detector for the FRISCV dispenser datapath. It drives the HC-SR04 trigger directly and times the echo pulse in centimetres. It supports single-shot and periodic measurement. The presence decision uses hysteresis thresholds plus N-consecutive-reading confirmation, and an echo timeout is flagged. It replaces the fixed single-shot, single-threshold presence compare in the FRISCV datapath.

---
 rtl/friscv_sensor_copo_if.sv | 22 ++
 rtl/friscv_sensor_copo.sv | 107 ++++++++++
 tb/tb_friscv_sensor_copo.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/friscv_sensor_copo_if.sv
// friscv_sensor_copo_if: HC-SR04 sensor/presence bus between the controller and the cup detector
// master drives echo, inicia_medida, habilita; slave drives trigger, fim_medida,
// copo_posicionado, erro_timeout, medida, db_estado
interface friscv_sensor_copo_if #(parameter int W = 12);
    logic         echo;
    logic         inicia_medida;
    logic         habilita;
    logic         trigger;
    logic         fim_medida;
    logic         copo_posicionado;
    logic         erro_timeout;
    logic [W-1:0] medida;
    logic [2:0]   db_estado;
    modport master (
        output echo, inicia_medida, habilita,
        input  trigger, fim_medida, copo_posicionado, erro_timeout, medida, db_estado
    );
    modport slave (
        input  echo, inicia_medida, habilita,
        output trigger, fim_medida, copo_posicionado, erro_timeout, medida, db_estado
    );
endinterface

// File: rtl/friscv_sensor_copo.sv
// friscv_sensor_copo: HC-SR04 cup-presence detector with hysteresis, N-reading confirmation and echo timeout
// clock, reset (async, active-high); bus.slave: echo, inicia_medida, habilita in;
// trigger, fim_medida, copo_posicionado, erro_timeout, medida[W], db_estado[3] out
module friscv_sensor_copo #(
    parameter int CICLOS_CM      = 2941,
    parameter int W              = 12,
    parameter int TRIG_CICLOS    = 500,
    parameter int TIMEOUT_CICLOS = 1_500_000,
    parameter int PERIODO_CICLOS = 5_000_000,
    parameter int LIMIAR_ON      = 5,
    parameter int LIMIAR_OFF     = 7,
    parameter int DIST_MIN       = 1,
    parameter int N_CONF         = 3
) (
    input logic clock,
    input logic reset,
    friscv_sensor_copo_if.slave bus
);
    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        DISPARO     = 3'd1,
        ESPERA_ECHO = 3'd2,
        MEDINDO     = 3'd3,
        ATUALIZA    = 3'd4,
        INTERVALO   = 3'd5
    } estado_t;
    localparam logic [W-1:0] L_ON  = W'(LIMIAR_ON);
    localparam logic [W-1:0] L_OFF = W'(LIMIAR_OFF);
    localparam logic [W-1:0] L_MIN = W'(DIST_MIN);
    estado_t      r_estado, w_prox;
    logic         r_echo_meta, r_echo_s;
    logic [31:0]  r_cnt_trig, r_cnt_per, r_cnt_to, r_cnt_ciclo;
    logic [W-1:0] r_cm, r_medida;
    logic [7:0]   r_conf;
    logic         r_trigger, r_fim, r_copo, r_erro;
    logic         w_to, w_conta, w_near, w_far, w_disc, w_opoe, w_toggle, w_per_fim;
    assign bus.trigger          = r_trigger;
    assign bus.fim_medida       = r_fim;
    assign bus.copo_posicionado = r_copo;
    assign bus.erro_timeout     = r_erro;
    assign bus.medida           = r_medida;
    assign bus.db_estado        = r_estado;
    always_comb begin
        w_prox    = r_estado;
        w_per_fim = r_cnt_per >= 32'(PERIODO_CICLOS - 1);
        w_to      = (r_estado == ESPERA_ECHO || r_estado == MEDINDO) && r_cnt_to >= 32'(TIMEOUT_CICLOS - 1);
        case (r_estado)
            OCIOSO:      w_prox = (bus.habilita || bus.inicia_medida) ? DISPARO : OCIOSO;
            DISPARO:     w_prox = (r_cnt_trig == 32'(TRIG_CICLOS - 1)) ? ESPERA_ECHO : DISPARO;
            ESPERA_ECHO: w_prox = w_to ? ATUALIZA : r_echo_s ? MEDINDO : ESPERA_ECHO;
            MEDINDO:     w_prox = (w_to || !r_echo_s) ? ATUALIZA : MEDINDO;
            // a late measurement re-triggers straight out of ATUALIZA
            ATUALIZA, INTERVALO: w_prox = !bus.habilita ? OCIOSO : w_per_fim ? DISPARO : INTERVALO;
            default:     w_prox = OCIOSO;
        endcase
        // the ESPERA_ECHO cycle that sees echo_s rise is counted, so d covers the whole pulse
        w_conta  = w_prox == MEDINDO && r_echo_s;
        w_near   = !w_to && r_cm >= L_MIN && r_cm <= L_ON;
        w_far    = w_to || r_cm > L_OFF;
        w_disc   = !w_to && r_cm < L_MIN;
        w_opoe   = r_copo ? w_far : w_near;
        w_toggle = w_opoe && r_conf + 8'd1 == 8'(N_CONF);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_cnt_trig  <= '0;
            r_cnt_per   <= '0;
            r_cnt_to    <= '0;
            r_cnt_ciclo <= '0;
            r_cm        <= '0;
            r_medida    <= '0;
            r_conf      <= '0;
            r_trigger   <= 1'b0;
            r_fim       <= 1'b0;
            r_copo      <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_estado    <= w_prox;
            r_echo_meta <= bus.echo;
            r_echo_s    <= r_echo_meta;
            r_trigger   <= w_prox == DISPARO;
            r_fim       <= w_prox == ATUALIZA;
            r_cnt_trig  <= r_estado == DISPARO ? r_cnt_trig + 32'd1 : '0;
            r_cnt_per   <= (w_prox == DISPARO && r_estado != DISPARO) ? '0
                         : r_cnt_per + 32'(r_cnt_per != 32'(PERIODO_CICLOS));
            r_cnt_to    <= (r_estado == ESPERA_ECHO || r_estado == MEDINDO) ? r_cnt_to + 32'd1 : '0;
            if (r_estado == DISPARO) begin
                r_cnt_ciclo <= '0;
                r_cm        <= '0;
            end else if (w_conta) begin
                r_cnt_ciclo <= r_cnt_ciclo == 32'(CICLOS_CM - 1) ? '0 : r_cnt_ciclo + 32'd1;
                if (r_cnt_ciclo == 32'(CICLOS_CM - 1) && r_cm != '1) r_cm <= r_cm + 1'b1;
            end
            if (w_prox == ATUALIZA) begin
                r_erro <= w_to;
                if (!w_to && r_cm >= L_MIN) r_medida <= r_cm;
                if (!w_disc) begin
                    r_conf <= (w_opoe && !w_toggle) ? r_conf + 8'd1 : '0;
                    if (w_toggle) r_copo <= !r_copo;
                end
            end
        end
    end
endmodule

// File: tb/tb_friscv_sensor_copo.sv
// tb_friscv_sensor_copo: scoreboard bench for the cup-presence detector
module tb_friscv_sensor_copo;
    typedef struct packed {
        logic [11:0] m;
        logic        e;
        logic        c;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t x;
    friscv_sensor_copo_if #(.W(12)) bus();
    friscv_sensor_copo #(
        .CICLOS_CM(10), .W(12), .TRIG_CICLOS(5), .TIMEOUT_CICLOS(2000), .PERIODO_CICLOS(3000),
        .LIMIAR_ON(5), .LIMIAR_OFF(7), .DIST_MIN(1), .N_CONF(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (bus.fim_medida) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_fim: fim_medida with no expected reading at cycle %0d", cyc);
            end else begin
                x = q.pop_front();
                if ({bus.medida, bus.erro_timeout, bus.copo_posicionado} !== x) begin
                    failures++;
                    $display("FAIL reading: got medida=%0d erro=%0d copo=%0d, expected medida=%0d erro=%0d copo=%0d",
                             bus.medida, bus.erro_timeout, bus.copo_posicionado, x.m, x.e, x.c);
                end
            end
        end
    end
    task automatic push(input logic [11:0] m, input logic e, input logic c);
        q.push_back('{m: m, e: e, c: c});
    endtask
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask
    task automatic pulse_inicia();
        bus.inicia_medida = 1'b1;
        @(negedge clock);
        bus.inicia_medida = 1'b0;
    endtask
    // sensor model: answers the next trigger with an echo of echo_len cycles, returns at fim_medida
    task automatic sensor(input int echo_len, output int trig_len, output int lat, output int t_rise);
        int n;
        n = 0;
        while (!bus.trigger && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (!bus.trigger) begin
            checks++;
            failures++;
            $display("FAIL trigger_wait: trigger=%0d after %0d cycles, required 1", bus.trigger, n);
        end
        t_rise = cyc;
        trig_len = 0;
        while (bus.trigger && trig_len < 5000) begin
            trig_len++;
            @(negedge clock);
        end
        lat = 0;
        while (!bus.fim_medida && lat < 5000) begin
            bus.echo = lat >= 3 && lat < 3 + echo_len;
            @(negedge clock);
            lat++;
        end
        bus.echo = 1'b0;
        if (!bus.fim_medida) begin
            checks++;
            failures++;
            $display("FAIL fim_wait: fim_medida=%0d after %0d cycles, required 1", bus.fim_medida, lat);
        end
    endtask
    task automatic test_reset();
        checks += 6;
        if (bus.trigger !== 1'b0) begin failures++; $display("FAIL rst_trigger: got %0d want 0", bus.trigger); end
        if (bus.fim_medida !== 1'b0) begin failures++; $display("FAIL rst_fim: got %0d want 0", bus.fim_medida); end
        if (bus.copo_posicionado !== 1'b0) begin failures++; $display("FAIL rst_copo: got %0d want 0", bus.copo_posicionado); end
        if (bus.erro_timeout !== 1'b0) begin failures++; $display("FAIL rst_erro: got %0d want 0", bus.erro_timeout); end
        if (bus.medida !== 12'd0) begin failures++; $display("FAIL rst_medida: got %0d want 0", bus.medida); end
        if (bus.db_estado !== 3'd0) begin failures++; $display("FAIL rst_estado: got %0d want 0", bus.db_estado); end
    endtask
    task automatic test_single_shot();
        int tl, lt, tr;
        push(12'd4, 1'b0, 1'b0);
        pulse_inicia();
        sensor(43, tl, lt, tr);
        checks++;
        if (tl !== 5) begin failures++; $display("FAIL trig_len: got %0d want 5", tl); end
        @(negedge clock);
        checks++;
        if (bus.fim_medida !== 1'b0) begin failures++; $display("FAIL fim_pulse: got %0d want 0", bus.fim_medida); end
    endtask
    task automatic test_periodic();
        int tl, lt, t1, t2, t3;
        apply_reset();
        push(12'd4, 1'b0, 1'b0);
        push(12'd4, 1'b0, 1'b0);
        push(12'd4, 1'b0, 1'b1);
        bus.habilita = 1'b1;
        sensor(40, tl, lt, t1);
        sensor(40, tl, lt, t2);
        sensor(40, tl, lt, t3);
        checks += 2;
        if (t2 - t1 !== 3000) begin failures++; $display("FAIL period_1: got %0d want 3000", t2 - t1); end
        if (t3 - t2 !== 3000) begin failures++; $display("FAIL period_2: got %0d want 3000", t3 - t2); end
    endtask
    task automatic test_hysteresis();
        int tl, lt, tr;
        int echoes[5] = '{80, 60, 80, 80, 80};
        push(12'd8, 1'b0, 1'b1);
        push(12'd6, 1'b0, 1'b1);
        push(12'd8, 1'b0, 1'b1);
        push(12'd8, 1'b0, 1'b1);
        push(12'd8, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sensor(echoes[i], tl, lt, tr);
    endtask
    task automatic test_timeout();
        int tl, lt, tr;
        push(12'd4, 1'b0, 1'b0);
        push(12'd4, 1'b0, 1'b0);
        push(12'd4, 1'b0, 1'b1);
        push(12'd4, 1'b1, 1'b1);
        push(12'd4, 1'b1, 1'b1);
        push(12'd4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) sensor(40, tl, lt, tr);
        for (int i = 0; i < 3; i++) begin
            sensor(0, tl, lt, tr);
            if (i == 2) bus.habilita = 1'b0;
            checks++;
            if (lt !== 2000) begin failures++; $display("FAIL timeout_lat: got %0d want 2000", lt); end
        end
        @(negedge clock);
    endtask
    task automatic test_discard_overflow();
        int tl, lt, tr;
        int echoes[4] = '{40, 5, 40, 40};
        push(12'd4, 1'b0, 1'b0);
        push(12'd4, 1'b0, 1'b0);
        push(12'd4, 1'b0, 1'b0);
        push(12'd4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pulse_inicia();
            sensor(echoes[i], tl, lt, tr);
            repeat (3) @(negedge clock);
        end
        push(12'd4, 1'b1, 1'b1);
        pulse_inicia();
        sensor(70000, tl, lt, tr);
        checks++;
        if (lt !== 2000) begin failures++; $display("FAIL long_echo_lat: got %0d want 2000", lt); end
        repeat (5) @(negedge clock);
    endtask
    task automatic test_async_reset();
        int n, tl, lt, tr;
        pulse_inicia();
        #2 reset = 1'b1;
        #1;
        checks += 2;
        if (bus.trigger !== 1'b0) begin failures++; $display("FAIL rst_mid_trigger: got %0d want 0", bus.trigger); end
        if (bus.db_estado !== 3'd0) begin failures++; $display("FAIL rst_mid_trig_estado: got %0d want 0", bus.db_estado); end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        pulse_inicia();
        n = 0;
        while (bus.trigger && n < 100) begin @(negedge clock); n++; end
        bus.echo = 1'b1;
        n = 0;
        while (bus.db_estado !== 3'd3 && n < 100) begin @(negedge clock); n++; end
        checks++;
        if (bus.db_estado !== 3'd3) begin failures++; $display("FAIL reach_medindo: got %0d want 3", bus.db_estado); end
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks += 5;
        if (bus.db_estado !== 3'd0) begin failures++; $display("FAIL rst_med_estado: got %0d want 0", bus.db_estado); end
        if (bus.copo_posicionado !== 1'b0) begin failures++; $display("FAIL rst_med_copo: got %0d want 0", bus.copo_posicionado); end
        if (bus.erro_timeout !== 1'b0) begin failures++; $display("FAIL rst_med_erro: got %0d want 0", bus.erro_timeout); end
        if (bus.medida !== 12'd0) begin failures++; $display("FAIL rst_med_medida: got %0d want 0", bus.medida); end
        if (bus.trigger !== 1'b0) begin failures++; $display("FAIL rst_med_trigger: got %0d want 0", bus.trigger); end
        @(negedge clock);
        bus.echo = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clock);
        push(12'd5, 1'b0, 1'b0);
        pulse_inicia();
        sensor(55, tl, lt, tr);
        checks++;
        if (tl !== 5) begin failures++; $display("FAIL trig_len_after_rst: got %0d want 5", tl); end
        repeat (3) @(negedge clock);
    endtask
    initial begin
        bus.echo = 1'b0;
        bus.inicia_medida = 1'b0;
        bus.habilita = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_single_shot();
        test_periodic();
        test_hysteresis();
        test_timeout();
        test_discard_overflow();
        test_async_reset();
        checks++;
        if (q.size() !== 0) begin failures++; $display("FAIL pending_readings: got %0d want 0", q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
